umi_sync_fifo: RTL and testbench



---
 rtl/umi_pkg.sv | 22 ++
 rtl/sync_fifo_core.sv | 71 +++++++
 rtl/umi_sync_fifo.sv | 97 +++++++++
 tb/tb_umi_sync_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/umi_pkg.sv
// Shared UMI definitions: default field widths, packet width helper and the
// packed packet layout {cmd, dstaddr, srcaddr, data} (cmd in the MSBs).
package umi_pkg;

  localparam int unsigned UMI_DW = 128;
  localparam int unsigned UMI_AW = 64;
  localparam int unsigned UMI_CW = 32;

  function automatic int unsigned umi_pkt_width(input int unsigned cw,
                                                input int unsigned aw,
                                                input int unsigned dw);
    return cw + 2 * aw + dw;
  endfunction

  typedef struct packed {
    logic [UMI_CW-1:0] cmd;
    logic [UMI_AW-1:0] dstaddr;
    logic [UMI_AW-1:0] srcaddr;
    logic [UMI_DW-1:0] data;
  } umi_pkt_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage with first-word fall-through read data.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en, wr_data    push an entry (caller guarantees !full)
//   rd_en, rd_data    pop the head entry (caller guarantees !empty);
//                     rd_data always shows the entry at the read pointer
//   full, empty       occupancy == DEPTH / occupancy == 0
module sync_fifo_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap at DEPTH-1 so non power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/umi_sync_fifo.sv
// UMI packet FIFO between a host and device channel.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   bypass                     1 = combinational pass-through, storage idle
//   chaosmode                  1 = output valid gated on alternate cycles
//   fifo_full, fifo_empty      storage occupancy flags
//   umi_in_*                   input packet valid/ready + fields
//   umi_out_*                  output packet valid/ready + fields
module umi_sync_fifo
  import umi_pkg::*;
#(
  parameter int unsigned DW    = UMI_DW,
  parameter int unsigned AW    = UMI_AW,
  parameter int unsigned CW    = UMI_CW,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bypass,
  input  logic          chaosmode,
  output logic          fifo_full,
  output logic          fifo_empty,
  input  logic          umi_in_valid,
  output logic          umi_in_ready,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data
);

  localparam int unsigned PW = umi_pkt_width(CW, AW, DW);

  logic [PW-1:0] wr_pkt;
  logic [PW-1:0] rd_pkt;
  logic          core_full;
  logic          core_empty;
  logic          toggle_q, toggle_d;
  logic          gate;
  logic          fifo_valid;
  logic          wr_en;
  logic          rd_en;

  assign toggle_d = ~toggle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign gate       = ~chaosmode | toggle_q;
  assign fifo_valid = ~core_empty & gate;
  assign wr_pkt     = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

  // Storage is only touched when not bypassing; in bypass the handshake
  // passes straight through and stored entries are held.
  assign wr_en = ~bypass & umi_in_valid & ~core_full;
  assign rd_en = ~bypass & fifo_valid & umi_out_ready;

  sync_fifo_core #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_pkt),
    .rd_en   (rd_en),
    .rd_data (rd_pkt),
    .full    (core_full),
    .empty   (core_empty)
  );

  always_comb begin
    if (bypass) begin
      umi_out_valid = umi_in_valid;
      umi_in_ready  = umi_out_ready;
      {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = wr_pkt;
    end else begin
      umi_out_valid = fifo_valid;
      umi_in_ready  = ~core_full;
      {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = rd_pkt;
    end
  end

  assign fifo_full  = core_full;
  assign fifo_empty = core_empty;

endmodule

// File: tb/tb_umi_sync_fifo.sv
// Self-checking bench for umi_sync_fifo with a queue-based reference model.
module tb_umi_sync_fifo;
  import umi_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          bypass;
  logic          chaosmode;
  logic          fifo_full;
  logic          fifo_empty;
  logic          umi_in_valid;
  logic          umi_in_ready;
  logic [31:0]   umi_in_cmd;
  logic [63:0]   umi_in_dstaddr;
  logic [63:0]   umi_in_srcaddr;
  logic [127:0]  umi_in_data;
  logic          umi_out_valid;
  logic          umi_out_ready;
  logic [31:0]   umi_out_cmd;
  logic [63:0]   umi_out_dstaddr;
  logic [63:0]   umi_out_srcaddr;
  logic [127:0]  umi_out_data;

  umi_sync_fifo #(
    .DW    (128),
    .AW    (64),
    .CW    (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bypass          (bypass),
    .chaosmode       (chaosmode),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .umi_in_valid    (umi_in_valid),
    .umi_in_ready    (umi_in_ready),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_out_valid   (umi_out_valid),
    .umi_out_ready   (umi_out_ready),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packet queue plus cycle parity since reset release.
  umi_pkt_t q[$];
  bit       tgl;
  int       checks;
  int       fails;
  int       obs_reads;
  int       exp_reads;

  task automatic check(input string tag, input logic [287:0] obs,
                       input logic [287:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic umi_pkt_t mk(input logic [31:0] c, input logic [63:0] d,
                                  input logic [63:0] s, input logic [127:0] x);
    umi_pkt_t p;
    p.cmd = c; p.dstaddr = d; p.srcaddr = s; p.data = x;
    return p;
  endfunction

  function automatic umi_pkt_t rnd_pkt();
    return mk($urandom, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom});
  endfunction

  // One clock cycle: drive at negedge, check mid-low-phase, update model at posedge.
  task automatic cyc(input logic v, input umi_pkt_t p, input logic ordy);
    logic     e_rdy, e_vld, acc, rd;
    umi_pkt_t e_pkt;
    umi_in_valid   = v;
    umi_in_cmd     = p.cmd;
    umi_in_dstaddr = p.dstaddr;
    umi_in_srcaddr = p.srcaddr;
    umi_in_data    = p.data;
    umi_out_ready  = ordy;
    #1;
    if (bypass) begin
      e_vld = v;
      e_rdy = ordy;
      e_pkt = p;
    end else begin
      e_rdy = (q.size() < DEPTH);
      e_vld = (q.size() != 0) && (!chaosmode || tgl);
      e_pkt = (q.size() != 0) ? q[0] : '0;
    end
    check("out_valid", 288'(umi_out_valid), 288'(e_vld));
    check("in_ready", 288'(umi_in_ready), 288'(e_rdy));
    check("fifo_full", 288'(fifo_full), 288'(q.size() == DEPTH));
    check("fifo_empty", 288'(fifo_empty), 288'(q.size() == 0));
    if (e_vld) begin
      check("out_fields", {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data},
            e_pkt);
    end
    if (umi_out_valid === 1'b1 && ordy) obs_reads++;
    acc = !bypass && v && e_rdy;
    rd  = !bypass && e_vld && ordy;
    if (rd) exp_reads++;
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (acc) q.push_back(p);
    tgl = !tgl;
    @(negedge clk);
  endtask

  initial begin
    umi_pkt_t p;
    checks = 0; fails = 0; obs_reads = 0; exp_reads = 0;
    reset = 1'b1; bypass = 1'b0; chaosmode = 1'b0;
    umi_in_valid = 1'b0; umi_out_ready = 1'b0;
    umi_in_cmd = '0; umi_in_dstaddr = '0; umi_in_srcaddr = '0; umi_in_data = '0;
    #3;
    check("rst_empty", 288'(fifo_empty), 288'(1'b1));
    check("rst_full", 288'(fifo_full), 288'(1'b0));
    check("rst_out_valid", 288'(umi_out_valid), 288'(1'b0));
    check("rst_in_ready", 288'(umi_in_ready), 288'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    tgl = 1'b0;

    // Idle, then single packet with downstream ready.
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, mk(32'h11, 64'h1000, 64'h2000, {4{32'hA5A5A5A5}}), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Fill to full, attempt a fifth packet, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, mk(32'(i), 64'(i), 64'(i), 128'(i)), 1'b0);
    cyc(1'b1, mk(32'h5, 64'h5, 64'h5, 128'h5), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);

    // Steady state at count 2 with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 2; i++) cyc(1'b1, mk(32'h77, 64'(i), 64'(i), 128'(i)), 1'b0);
    for (int i = 2; i < 12; i++) cyc(1'b1, mk(32'h77, 64'(i), 64'(i), 128'(i)), 1'b1);
    check("steady_count2", 288'(q.size() == 2 && !fifo_empty && !fifo_full), 288'(1'b1));
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

    // Bypass with empty storage.
    bypass = 1'b1;
    cyc(1'b1, mk(32'h1, 64'h2, 64'h3, 128'h5), 1'b1);
    cyc(1'b1, mk(32'h1, 64'h2, 64'h3, 128'h5), 1'b0);
    cyc(1'b0, rnd_pkt(), 1'b1);
    bypass = 1'b0;
    cyc(1'b0, '0, 1'b1);

    // Chaos mode with a continuous stream.
    chaosmode = 1'b1;
    obs_reads = 0; exp_reads = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, mk(32'hC0 + 32'(i), 64'(i), 64'(i), 128'(i)), 1'b1);
    check("chaos_rate_le_half", 288'(obs_reads <= 8), 288'(1'b1));
    check("chaos_reads", 288'(obs_reads), 288'(exp_reads));
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);
    chaosmode = 1'b0;

    // Mid-operation reset discards entries at once.
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_pkt(), 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_empty", 288'(fifo_empty), 288'(1'b1));
    check("midrst_full", 288'(fifo_full), 288'(1'b0));
    check("midrst_out_valid", 288'(umi_out_valid), 288'(1'b0));
    check("midrst_in_ready", 288'(umi_in_ready), 288'(1'b1));
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    tgl = 1'b0;

    // Randomized traffic with occasional chaos mode.
    for (int blk = 0; blk < 10; blk++) begin
      chaosmode = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 25; i++) begin
        p = rnd_pkt();
        cyc(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 3) != 0));
      end
    end
    chaosmode = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
